hour_preset_sequencer: RTL and testbench

// - Drives the add/sub/hold-aware 0..23 BCD hour counter to a requested hour by issuing single-cycle step pulses.
// - Reads the counter's BCD high/low digits as feedback and takes the shorter direction modulo 24.
// - Sits between the time-set UI (switches/buttons) and the hour counter; the counter's own hold and rst stay external.

---
 rtl/hour_pkg.sv | 22 ++
 rtl/bcd_hour_to_bin.sv | 18 +
 rtl/hour_preset_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_hour_preset_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/hour_pkg.sv
// Shared definitions for the hour preset sequencer: dial geometry,
// FSM state encoding and step direction.
package hour_pkg;

    localparam int HOURS = 24;
    localparam int HALF  = 12;
    localparam int BIN_W = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_PULSE,
        S_WAIT,
        S_DONE
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/bcd_hour_to_bin.sv
// Converts a BCD hour pair (tens, units) to a 0..23 binary value and flags
// pairs that are not a legal hour.
module bcd_hour_to_bin
    import hour_pkg::*;
(
    input  logic [3:0]       bcd_high_i,
    input  logic [3:0]       bcd_low_i,
    output logic [BIN_W-1:0] bin_o,
    output logic             valid_o
);

    // Only tens digits 0..2 are meaningful; the value wraps for illegal pairs, which valid_o rejects.
    assign bin_o = BIN_W'(bcd_high_i[1:0]) * BIN_W'(10) + BIN_W'(bcd_low_i);

    assign valid_o = (bcd_high_i <= 4'd2) && (bcd_low_i <= 4'd9) &&
                     !((bcd_high_i == 4'd2) && (bcd_low_i > 4'd3));

endmodule

// File: rtl/hour_preset_sequencer.sv
// Steps an external 0..23 BCD hour counter to a requested hour with single-cycle
// add/sub pulses, taking the shorter way round the dial.
module hour_preset_sequencer
    import hour_pkg::*;
#(
    parameter int PULSE_GAP = 1,
    parameter int MAX_STEPS = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] tgt_high,
    input  logic [3:0] tgt_low,
    input  logic [3:0] cur_high,
    input  logic [3:0] cur_low,
    input  logic       cnt_hold,
    output logic       add,
    output logic       sub,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int STEP_W = $clog2(MAX_STEPS + 1);
    localparam int GAP_W  = (PULSE_GAP > 1) ? $clog2(PULSE_GAP) : 1;
    localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(MAX_STEPS);
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(PULSE_GAP - 1);

    state_t              state_q, state_d;
    logic [3:0]          tgt_high_q, tgt_high_d;
    logic [3:0]          tgt_low_q, tgt_low_d;
    dir_t                dir_q, dir_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                pulse_q, pulse_d;
    logic                fail_d;
    logic                add_q, add_d;
    logic                sub_q, sub_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [BIN_W-1:0]    tgt_bin, cur_bin;
    logic                tgt_valid, cur_valid;
    logic [BIN_W:0]      up;
    logic                match;

    bcd_hour_to_bin u_tgt_conv (
        .bcd_high_i (tgt_high_q),
        .bcd_low_i  (tgt_low_q),
        .bin_o      (tgt_bin),
        .valid_o    (tgt_valid)
    );

    bcd_hour_to_bin u_cur_conv (
        .bcd_high_i (cur_high),
        .bcd_low_i  (cur_low),
        .bin_o      (cur_bin),
        .valid_o    (cur_valid)
    );

    // Forward distance round the dial; an extra bit keeps the +HOURS wrap from overflowing.
    assign up = (tgt_bin >= cur_bin) ? ({1'b0, tgt_bin} - {1'b0, cur_bin})
                                     : ({1'b0, tgt_bin} + (BIN_W+1)'(HOURS) - {1'b0, cur_bin});

    assign match = cur_valid && (cur_bin == tgt_bin);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tgt_high_q <= '0;
            tgt_low_q  <= '0;
            dir_q      <= DIR_UP;
            step_q     <= '0;
            gap_q      <= '0;
            pulse_q    <= 1'b0;
            add_q      <= 1'b0;
            sub_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q    <= state_d;
            tgt_high_q <= tgt_high_d;
            tgt_low_q  <= tgt_low_d;
            dir_q      <= dir_d;
            step_q     <= step_d;
            gap_q      <= gap_d;
            pulse_q    <= pulse_d;
            add_q      <= add_d;
            sub_q      <= sub_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
        state_d    = state_q;
        tgt_high_d = tgt_high_q;
        tgt_low_d  = tgt_low_q;
        dir_d      = dir_q;
        step_d     = step_q;
        gap_d      = gap_q;
        pulse_d    = 1'b0;
        fail_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    tgt_high_d = tgt_high;
                    tgt_low_d  = tgt_low;
                    step_d     = '0;
                    state_d    = S_CALC;
                end
            end
            S_CALC: begin
                if (!tgt_valid) begin
                    state_d = S_DONE;
                    fail_d  = 1'b1;
                end else if (up == '0) begin
                    state_d = S_DONE;
                end else begin
                    dir_d   = (up <= (BIN_W+1)'(HALF)) ? DIR_UP : DIR_DOWN;
                    state_d = S_PULSE;
                    pulse_d = !cnt_hold;
                end
            end
            // pulse_q marks the cycle the step is on the wire; otherwise we are held off.
            S_PULSE: begin
                if (pulse_q) begin
                    state_d = S_WAIT;
                    gap_d   = GAP_LOAD;
                end else begin
                    pulse_d = !cnt_hold;
                end
            end
            S_WAIT: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end else if (match) begin
                    state_d = S_DONE;
                end else if (step_q == STEP_MAX) begin
                    state_d = S_DONE;
                    fail_d  = 1'b1;
                end else begin
                    state_d = S_PULSE;
                    pulse_d = !cnt_hold;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d = S_IDLE;
            pulse_d = 1'b0;
            fail_d  = 1'b0;
        end

        if (pulse_d) begin
            step_d = step_q + 1'b1;
        end
    end

    // Outputs are decoded from next-state values and registered, so pins never see input glitches.
    always_comb begin
        add_d  = pulse_d && (dir_d == DIR_UP);
        sub_d  = pulse_d && (dir_d == DIR_DOWN);
        busy_d = (state_d == S_CALC) || (state_d == S_PULSE) || (state_d == S_WAIT);
        done_d = (state_d == S_DONE);
        err_d  = fail_d;
    end

    assign add  = add_q;
    assign sub  = sub_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_hour_preset_sequencer.sv
// Bench for hour_preset_sequencer: a behavioural BCD hour counter closes the
// feedback loop and a scoreboard checks every add/sub/done event and its cycle.
module tb_hour_preset_sequencer;

    localparam int EV_ADD  = 1;
    localparam int EV_SUB  = 2;
    localparam int EV_DONE = 3;

    typedef struct {
        int kind;
        int cyc;
        bit err;
    } exp_t;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       start    = 1'b0;
    logic       abort    = 1'b0;
    logic [3:0] tgt_high = 4'd0;
    logic [3:0] tgt_low  = 4'd0;
    logic       cnt_hold = 1'b0;
    logic [3:0] cur_high, cur_low;
    logic       add, sub, busy, done, err;

    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    int   hour     = 0;
    bit   frozen   = 1'b0;
    bit   set_en   = 1'b0;
    int   set_val  = 0;
    exp_t exp_q[$];

    hour_preset_sequencer #(
        .PULSE_GAP (1),
        .MAX_STEPS (13)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .tgt_high (tgt_high),
        .tgt_low  (tgt_low),
        .cur_high (cur_high),
        .cur_low  (cur_low),
        .cnt_hold (cnt_hold),
        .add      (add),
        .sub      (sub),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External hour counter: honours hold, can be frozen to model a stuck counter.
    always @(posedge clk) begin
        if (set_en) begin
            hour <= set_val;
        end else if (!frozen && !cnt_hold) begin
            if (add)      hour <= (hour + 1) % 24;
            else if (sub) hour <= (hour + 23) % 24;
        end
    end

    assign cur_high = 4'(hour / 10);
    assign cur_low  = 4'(hour % 10);

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   act_kind;
        if (!rst) begin
            if (err) check("err_only_with_done", int'(done), 1);
            if (add || sub || done) begin
                if (add || sub) check("add_sub_exclusive", int'(add && sub), 0);
                act_kind = done ? EV_DONE : (add ? EV_ADD : EV_SUB);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", act_kind, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", act_kind, e.kind);
                    check("event_cycle", cyc, e.cyc);
                    if (done) begin
                        check("err_at_done", int'(err), int'(e.err));
                        check("busy_at_done", int'(busy), 0);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic set_counter(input int h, input bit frz);
        tick();
        set_val = h;
        set_en  = 1'b1;
        frozen  = frz;
        tick();
        set_en  = 1'b0;
    endtask

    task automatic issue(input int th, input int tl, output int k);
        tick();
        k        = cyc;
        start    = 1'b1;
        tgt_high = 4'(th);
        tgt_low  = 4'(tl);
        tick();
        start    = 1'b0;
        check("busy_in_calc", int'(busy), 1);
    endtask

    task automatic push_ev(input int kind, input int c, input bit e);
        exp_t x;
        x.kind = kind;
        x.cyc  = c;
        x.err  = e;
        exp_q.push_back(x);
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        check({name, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
        tick();
        check({name, "_idle_busy"}, int'(busy), 0);
    endtask

    task automatic run_req(input string name, input int h, input int th, input int tl,
                           input int n, input int kind, input bit e, input bit frz);
        int k;
        set_counter(h, frz);
        issue(th, tl, k);
        for (int i = 0; i < n; i++) push_ev(kind, k + 2 + 2 * i, 1'b0);
        push_ev(EV_DONE, k + 2 + 2 * n, e);
        wait_drain(name, 80);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;

        #1 rst = 1'b1;
        tick();
        check("reset_add", int'(add), 0);
        check("reset_sub", int'(sub), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_err", int'(err), 0);
        rst = 1'b0;
        tick();

        run_req("up_05_to_08",   5,  0,  8,  3, EV_ADD, 1'b0, 1'b0);
        run_req("down_01_to_22", 1,  2,  2,  3, EV_SUB, 1'b0, 1'b0);
        run_req("tie_00_to_12",  0,  1,  2, 12, EV_ADD, 1'b0, 1'b0);
        run_req("same_10",       10, 1,  0,  0, EV_ADD, 1'b0, 1'b0);
        run_req("bad_24",        5,  2,  4,  0, EV_ADD, 1'b1, 1'b0);
        run_req("bad_1A",        5,  1, 10,  0, EV_ADD, 1'b1, 1'b0);
        run_req("wrap_23_to_01", 23, 0,  1,  2, EV_ADD, 1'b0, 1'b0);
        run_req("frozen_budget", 5,  0,  8, 13, EV_ADD, 1'b1, 1'b1);

        set_counter(5, 1'b0);
        issue(0, 8, k);
        push_ev(EV_ADD, k + 2, 1'b0);
        push_ev(EV_ADD, k + 9, 1'b0);
        push_ev(EV_ADD, k + 11, 1'b0);
        push_ev(EV_DONE, k + 13, 1'b0);
        wait_until(k + 3);
        cnt_hold = 1'b1;
        wait_until(k + 8);
        cnt_hold = 1'b0;
        wait_drain("hold_5", 40);
        check("hold_final_hour", hour, 8);

        set_counter(5, 1'b0);
        issue(2, 0, k);
        push_ev(EV_SUB, k + 2, 1'b0);
        wait_until(k + 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy_drop", int'(busy), 0);
        for (int i = 0; i < 6; i++) tick();
        wait_drain("abort_wait", 1);
        check("abort_final_hour", hour, 4);

        set_counter(5, 1'b0);
        issue(0, 8, k);
        push_ev(EV_ADD, k + 2, 1'b0);
        wait_until(k + 2);
        check("pre_rst_add", int'(add), 1);
        rst = 1'b1;
        #1;
        check("rst_add_async", int'(add), 0);
        check("rst_sub", int'(sub), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        wait_drain("rst_mid_pulse", 1);

        run_req("after_rst", 20, 2, 3, 3, EV_ADD, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
